// File: rtl/mvm_axis_driver.sv
// AXI-Stream initiator for MVM tile bring-up: queues host commands, issues them as
// single-beat packets and scores the returned results.
module mvm_axis_driver #(
   parameter int DATAW   = 32,
   parameter int DESTW   = 6,
   parameter int USERW   = 32,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [DATAW-1:0] cmd_data,
   input  logic [DESTW-1:0] cmd_dest,
   input  logic             cmd_check,
   input  logic [DATAW-1:0] cmd_expect,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic [DATAW-1:0] m_axis_tdata,
   output logic [DESTW-1:0] m_axis_tdest,
   output logic [USERW-1:0] m_axis_tuser,
   output logic             m_axis_tlast,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic [DATAW-1:0] s_axis_tdata,
   output logic             busy,
   output logic [15:0]      pass_count,
   output logic [15:0]      err_count,
   output logic [15:0]      timeout_count,
   output logic [15:0]      stray_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef struct packed {
      logic [1:0]       op;
      logic [DATAW-1:0] data;
      logic [DESTW-1:0] dest;
      logic             chk;
      logic [DATAW-1:0] exp_data;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   entry_t           mem_r [DEPTH];
   entry_t           new_s;
   entry_t           head_s;
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;
   state_t           state_r;
   logic             chk_r;
   logic [DATAW-1:0] exp_r;
   logic [TW-1:0]    tmo_cnt_r;

   // Only input words can be checked; the check flag is masked at push time.
   assign new_s   = {cmd_op, cmd_data, cmd_dest, cmd_check && (cmd_op == 2'd2), cmd_expect};
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign push_s  = cmd_valid && !full_s;
   assign pop_s   = (state_r == IDLE) && !empty_s;
   assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

   assign cmd_ready     = !full_s;
   assign s_axis_tready = 1'b1;
   assign busy          = !empty_s || (state_r != IDLE);

   // Command storage write port.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= new_s;
      end
   end

   // FIFO pointers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Issue/response FSM with registered AXIS outputs and statistics.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= IDLE;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tdest  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         chk_r         <= 1'b0;
         exp_r         <= '0;
         tmo_cnt_r     <= '0;
         pass_count    <= 16'd0;
         err_count     <= 16'd0;
         timeout_count <= 16'd0;
         stray_count   <= 16'd0;
      end else begin
         if (s_axis_tvalid && (state_r != WAIT_RSP)) begin
            stray_count <= sat_inc(stray_count);
         end
         case (state_r)
            IDLE: begin
               if (!empty_s) begin
                  m_axis_tdata <= head_s.data;
                  m_axis_tdest <= head_s.dest;
                  m_axis_tuser <= {head_s.op, {(USERW-2){1'b0}}};
                  m_axis_tlast <= 1'b1;
                  chk_r        <= head_s.chk;
                  exp_r        <= head_s.exp_data;
                  state_r      <= SEND;
               end
            end
            SEND: begin
               // Payload is loaded one edge ahead so tvalid never rises on unstable data.
               if (!m_axis_tvalid) begin
                  m_axis_tvalid <= 1'b1;
               end else if (m_axis_tready) begin
                  m_axis_tvalid <= 1'b0;
                  tmo_cnt_r     <= '0;
                  state_r       <= chk_r ? WAIT_RSP : IDLE;
               end
            end
            WAIT_RSP: begin
               if (s_axis_tvalid) begin
                  if (s_axis_tdata == exp_r) begin
                     pass_count <= sat_inc(pass_count);
                  end else begin
                     err_count <= sat_inc(err_count);
                  end
                  state_r <= IDLE;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  timeout_count <= sat_inc(timeout_count);
                  err_count     <= sat_inc(err_count);
                  state_r       <= IDLE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mvm_axis_driver.sv
// Scoreboard bench for mvm_axis_driver with a byte-lane multiply MVM model on the
// response path.
module tb_mvm_axis_driver;

   localparam int DATAW   = 32;
   localparam int DESTW   = 6;
   localparam int USERW   = 32;
   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 100;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [DATAW-1:0] cmd_data;
   logic [DESTW-1:0] cmd_dest;
   logic             cmd_check;
   logic [DATAW-1:0] cmd_expect;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic [DATAW-1:0] m_axis_tdata;
   logic [DESTW-1:0] m_axis_tdest;
   logic [USERW-1:0] m_axis_tuser;
   logic             m_axis_tlast;
   logic             s_axis_tvalid;
   logic             s_axis_tready;
   logic [DATAW-1:0] s_axis_tdata;
   logic             busy;
   logic [15:0]      pass_count;
   logic [15:0]      err_count;
   logic [15:0]      timeout_count;
   logic [15:0]      stray_count;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] data;
      logic [5:0]  dest;
   } beat_t;

   beat_t       exp_q[$];
   int          checks     = 0;
   int          failures   = 0;
   int          beats      = 0;
   int          stray_seq  = 0;
   logic        model_mute = 1'b0;
   beat_t       mon_hd;
   beat_t       mdl_b;
   logic        mdl_hs;
   logic [31:0] mdl_w;
   int          mdl_done;

   always #5 clk = ~clk;

   mvm_axis_driver #(
      .DATAW(DATAW), .DESTW(DESTW), .USERW(USERW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .cmd_dest(cmd_dest), .cmd_check(cmd_check), .cmd_expect(cmd_expect),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .busy(busy), .pass_count(pass_count), .err_count(err_count),
      .timeout_count(timeout_count), .stray_count(stray_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] mvm(input logic [31:0] w, input logic [31:0] x);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = w[8*b +: 8] * x[8*b +: 8];
      end
      return r;
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Caller is 1 time unit after a rising edge; returns likewise after acceptance.
   task automatic push(input logic [1:0] op, input logic [31:0] data, input logic [5:0] dest,
                       input logic chk_en, input logic [31:0] expv);
      bit done = 1'b0;
      int n    = 0;
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_data   = data;
      cmd_dest   = dest;
      cmd_check  = chk_en;
      cmd_expect = expv;
      while (!done) begin
         @(negedge clk);
         if (cmd_ready) begin
            done = 1'b1;
            exp_q.push_back('{op: op, data: data, dest: dest});
         end else if (n >= 300) begin
            done = 1'b1;
            checks++;
            failures++;
            $display("FAIL push_accept actual=stalled required=accepted data=%h", data);
         end
         n++;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 1000);
      chk("wait_idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic wait_handshake(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_axis_tvalid && m_axis_tready) && n < 200);
      chk(name, 32'(m_axis_tvalid && m_axis_tready), 32'd1);
   endtask

   // Monitor: every presented beat must match the head of the expected queue.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual=%h required=none", m_axis_tdata);
            end else begin
               mon_hd = exp_q[0];
               chk("beat_tdata", m_axis_tdata, mon_hd.data);
               chk("beat_tuser", m_axis_tuser, {mon_hd.op, 30'b0});
               chk("beat_tdest", 32'(m_axis_tdest), 32'(mon_hd.dest));
               chk("beat_tlast", 32'(m_axis_tlast), 32'd1);
               if (m_axis_tready) begin
                  void'(exp_q.pop_front());
                  beats++;
               end
            end
         end
      end
   end

   // MVM model: op=3 loads weights, op=2 returns byte-lane products one cycle later.
   initial begin
      mdl_w         = 32'd0;
      mdl_done      = 0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 32'd0;
      forever begin
         @(negedge clk);
         mdl_hs     = (rst === 1'b1) && m_axis_tvalid && m_axis_tready;
         mdl_b.op   = m_axis_tuser[31:30];
         mdl_b.data = m_axis_tdata;
         mdl_b.dest = m_axis_tdest;
         @(posedge clk);
         #1;
         s_axis_tvalid = 1'b0;
         s_axis_tdata  = 32'd0;
         if (mdl_done != stray_seq) begin
            mdl_done      = stray_seq;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hDEADBEEF;
         end else if (mdl_hs && mdl_b.op == 2'd3) begin
            mdl_w = mdl_b.data;
         end else if (mdl_hs && mdl_b.op == 2'd2 && !model_mute) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = mvm(mdl_w, mdl_b.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] op_tab [3];
      int         b0;
      op_tab[0]     = 2'd0;
      op_tab[1]     = 2'd1;
      op_tab[2]     = 2'd3;
      rst           = 1'b0;
      cmd_valid     = 1'b0;
      cmd_op        = 2'd0;
      cmd_data      = 32'd0;
      cmd_dest      = 6'd0;
      cmd_check     = 1'b0;
      cmd_expect    = 32'd0;
      m_axis_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tdata", m_axis_tdata, 32'd0);
      chk("rst_tuser", m_axis_tuser, 32'd0);
      chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_s_tready", 32'(s_axis_tready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_counters", {pass_count, err_count | timeout_count | stray_count}, 32'd0);

      // Weight load then checked input, with issue latency
      sync();
      push(2'd3, 32'h03000000, 6'd5, 1'b0, 32'd0);
      @(negedge clk);
      chk("lat_edge_n", 32'(m_axis_tvalid), 32'd0);
      @(negedge clk);
      chk("lat_edge_n1", 32'(m_axis_tvalid), 32'd0);
      @(negedge clk);
      chk("lat_edge_n2", 32'(m_axis_tvalid), 32'd1);
      sync();
      push(2'd2, 32'h05000000, 6'd5, 1'b1, 32'h0F000000);
      wait_idle();
      chk("t1_pass", 32'(pass_count), 32'd1);
      chk("t1_err", 32'(err_count), 32'd0);
      chk("t1_beats", 32'(beats), 32'd2);

      // Backpressure: 0x03 * 0x02 in the top lane gives 0x06000000
      sync();
      m_axis_tready = 1'b0;
      push(2'd2, 32'h02020202, 6'd9, 1'b1, 32'h06000000);
      begin
         int n = 0;
         while (!m_axis_tvalid && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      b0 = beats;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
         chk("bp_tdata", m_axis_tdata, 32'h02020202);
      end
      sync();
      m_axis_tready = 1'b1;
      wait_idle();
      chk("bp_one_beat", 32'(beats - b0), 32'd1);
      chk("bp_pass", 32'(pass_count), 32'd2);

      // Mismatch: zero weights give zero result
      sync();
      push(2'd3, 32'h00000000, 6'd1, 1'b0, 32'd0);
      push(2'd2, 32'h01010101, 6'd1, 1'b1, 32'h01010101);
      wait_idle();
      chk("mm_err", 32'(err_count), 32'd1);
      chk("mm_pass", 32'(pass_count), 32'd2);

      // Timeout: fires TIMEOUT edges after WAIT_RSP entry
      model_mute = 1'b1;
      sync();
      push(2'd2, 32'h12345678, 6'd2, 1'b1, 32'h12345678);
      wait_handshake("tmo_handshake");
      repeat (TIMEOUT) @(negedge clk);
      chk("tmo_early", 32'(timeout_count), 32'd0);
      chk("tmo_early_err", 32'(err_count), 32'd1);
      @(negedge clk);
      chk("tmo_count", 32'(timeout_count), 32'd1);
      chk("tmo_err", 32'(err_count), 32'd2);
      chk("tmo_busy", 32'(busy), 32'd0);

      // FIFO full: 8 queued plus 1 held in SEND
      sync();
      m_axis_tready = 1'b0;
      b0 = beats;
      for (int i = 0; i < 9; i++) begin
         push(op_tab[i % 3], 32'hA0000000 + 32'(i), 6'(i), 1'b0, 32'd0);
      end
      @(negedge clk);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("full_busy", 32'(busy), 32'd1);
      sync();
      cmd_valid = 1'b1;
      cmd_op    = op_tab[0];
      cmd_data  = 32'hA0000009;
      cmd_dest  = 6'd9;
      cmd_check = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_stall", 32'(cmd_ready), 32'd0);
      end
      sync();
      m_axis_tready = 1'b1;
      push(op_tab[0], 32'hA0000009, 6'd9, 1'b0, 32'd0);
      wait_idle();
      chk("full_beats", 32'(beats - b0), 32'd10);
      chk("full_q_empty", 32'(exp_q.size()), 32'd0);

      // Stray beat in IDLE, then reset while waiting for a response
      sync();
      stray_seq++;
      repeat (4) @(negedge clk);
      chk("stray_count", 32'(stray_count), 32'd1);
      chk("stray_pass", 32'(pass_count), 32'd2);
      chk("stray_err", 32'(err_count), 32'd2);
      sync();
      push(2'd2, 32'h00000001, 6'd3, 1'b1, 32'h00000077);
      wait_handshake("rst_handshake");
      repeat (10) @(negedge clk);
      chk("rst_inflight_busy", 32'(busy), 32'd1);
      sync();
      rst = 1'b0;
      sync();
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst2_tdata", m_axis_tdata, 32'd0);
      chk("rst2_tdest", 32'(m_axis_tdest), 32'd0);
      chk("rst2_tuser", m_axis_tuser, 32'd0);
      chk("rst2_tlast", 32'(m_axis_tlast), 32'd0);
      chk("rst2_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst2_busy", 32'(busy), 32'd0);
      chk("rst2_pass_err", {pass_count, err_count}, 32'd0);
      chk("rst2_tmo_stray", {timeout_count, stray_count}, 32'd0);
      repeat (TIMEOUT + 5) @(negedge clk);
      chk("rst2_late_counters", {pass_count | stray_count, err_count | timeout_count}, 32'd0);
      chk("rst2_late_busy", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
